// File: rtl/axi_wr_route_ctrl_if.sv
`timescale 1ns/1ps
// axi_wr_route_ctrl_if
// Bundles the master-side and per-slave handshake signals of the write
// channel that pass through the routing controller.
//   master modport : the environment side (master + slaves), which drives the
//                    controller inputs and observes its gated outputs.
//   slave  modport : the controller's own view of the bus.
// Signals keep the names used throughout the interconnect (M_* = master side,
// S_* = per-slave vectors, where bit n belongs to slave n).
interface axi_wr_route_ctrl_if #(
   parameter int ADDR_WIDTH = 32
);
   logic                  M_AWVALID;
   logic [ADDR_WIDTH-1:0] M_AWADDR;
   logic [7:0]            M_AWLEN;
   logic                  M_AWREADY;
   logic [1:0]            S_AWVALID;
   logic [1:0]            S_AWREADY;
   logic                  M_WVALID;
   logic                  M_WLAST;
   logic                  M_WREADY;
   logic [1:0]            S_WVALID;
   logic [1:0]            S_WREADY;
   logic [1:0]            S_BVALID;
   logic [1:0]            S_BRESP0;
   logic [1:0]            S_BRESP1;
   logic [1:0]            S_BREADY;
   logic                  M_BVALID;
   logic [1:0]            M_BRESP;
   logic                  M_BREADY;

   modport slave (
      input  M_AWVALID, M_AWADDR, M_AWLEN, S_AWREADY,
      input  M_WVALID, M_WLAST, S_WREADY,
      input  S_BVALID, S_BRESP0, S_BRESP1, M_BREADY,
      output M_AWREADY, S_AWVALID, M_WREADY, S_WVALID,
      output S_BREADY, M_BVALID, M_BRESP
   );

   modport master (
      output M_AWVALID, M_AWADDR, M_AWLEN, S_AWREADY,
      output M_WVALID, M_WLAST, S_WREADY,
      output S_BVALID, S_BRESP0, S_BRESP1, M_BREADY,
      input  M_AWREADY, S_AWVALID, M_WREADY, S_WVALID,
      input  S_BREADY, M_BVALID, M_BRESP
   );
endinterface

// File: rtl/axi_wr_route_ctrl.sv
`timescale 1ns/1ps
// axi_wr_route_ctrl
// Write-channel routing controller for a single-master, two-slave AXI
// interconnect. Decodes the write address into a registered slave select,
// allows exactly one write transaction in flight (AW -> W -> B), gates every
// valid/ready toward the unselected slave, and forces SLVERR when the number
// of W beats disagrees with AWLEN.
// Ports:
//   ACLK   : clock, rising edge
//   ARESET : asynchronous active-high reset
//   bus    : write-channel handshakes (axi_wr_route_ctrl_if.slave)
//   sel    : registered slave select for the AW/W demux and B mux
//   busy   : high whenever a transaction is in progress (state != IDLE)
module axi_wr_route_ctrl #(
   parameter int                    ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] S1_BASE    = 32'h8000_0000
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   axi_wr_route_ctrl_if.slave    bus,
   output logic                  sel,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_AW,
      ST_W,
      ST_B
   } state_t;

   state_t     state;
   logic [7:0] len;
   logic [8:0] beat;
   logic       len_err;

   logic       m_awready;
   logic [1:0] s_awvalid;
   logic       m_wready;
   logic [1:0] s_wvalid;
   logic [1:0] s_bready;
   logic       m_bvalid;
   logic [1:0] m_bresp;

   // Channel gating: only the selected slave ever sees a valid or ready, and
   // only while the FSM is in that channel's phase. Everything else is 0, so
   // early W data and stray B responses are simply held off.
   always_comb begin
      m_awready = 1'b0;
      s_awvalid = '0;
      m_wready  = 1'b0;
      s_wvalid  = '0;
      s_bready  = '0;
      m_bvalid  = 1'b0;
      m_bresp   = '0;
      case (state)
         ST_AW: begin
            s_awvalid[sel] = bus.M_AWVALID;
            m_awready      = bus.S_AWREADY[sel];
         end
         ST_W: begin
            s_wvalid[sel] = bus.M_WVALID;
            m_wready      = bus.S_WREADY[sel];
         end
         ST_B: begin
            m_bvalid      = bus.S_BVALID[sel];
            s_bready[sel] = bus.M_BREADY;
            if (len_err)
               m_bresp = 2'b10;
            else
               m_bresp = sel ? bus.S_BRESP1 : bus.S_BRESP0;
         end
         default: ;
      endcase
   end

   assign bus.M_AWREADY = m_awready;
   assign bus.S_AWVALID = s_awvalid;
   assign bus.M_WREADY  = m_wready;
   assign bus.S_WVALID  = s_wvalid;
   assign bus.S_BREADY  = s_bready;
   assign bus.M_BVALID  = m_bvalid;
   assign bus.M_BRESP   = m_bresp;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state   <= ST_IDLE;
         sel     <= 1'b0;
         len     <= '0;
         beat    <= '0;
         len_err <= 1'b0;
         busy    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.M_AWVALID) begin
                  sel     <= (bus.M_AWADDR >= S1_BASE);
                  len     <= bus.M_AWLEN;
                  beat    <= '0;
                  len_err <= 1'b0;
                  busy    <= 1'b1;
                  state   <= ST_AW;
               end
            end
            ST_AW: begin
               if (bus.M_AWVALID && m_awready)
                  state <= ST_W;
            end
            ST_W: begin
               if (bus.M_WVALID && m_wready) begin
                  beat <= beat + 9'd1;
                  // Only WLAST ends the burst; a short or overlong burst is
                  // flagged by comparing the pre-increment count against len.
                  if (bus.M_WLAST) begin
                     len_err <= (beat != {1'b0, len});
                     state   <= ST_B;
                  end
               end
            end
            ST_B: begin
               if (m_bvalid && bus.M_BREADY) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_wr_route_ctrl.sv
`timescale 1ns/1ps
module tb_axi_wr_route_ctrl;

   logic ACLK;
   logic ARESET;
   logic sel;
   logic busy;

   axi_wr_route_ctrl_if #(.ADDR_WIDTH(32)) bus ();

   axi_wr_route_ctrl #(
      .ADDR_WIDTH (32),
      .S1_BASE    (32'h8000_0000)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus),
      .sel    (sel),
      .busy   (busy)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   typedef struct {
      logic       sel;
      logic [1:0] resp;
      int         beats;
      int         cycles;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0;
   int   fails = 0;

   logic [12:0] outs;
   assign outs = {bus.M_AWREADY, bus.S_AWVALID, bus.M_WREADY, bus.S_WVALID,
                  bus.S_BREADY, bus.M_BVALID, bus.M_BRESP, busy, sel};

   task automatic drive_idle();
      bus.M_AWVALID = 1'b0;
      bus.M_AWADDR  = '0;
      bus.M_AWLEN   = '0;
      bus.M_WVALID  = 1'b0;
      bus.M_WLAST   = 1'b0;
      bus.S_AWREADY = 2'b11;
      bus.S_WREADY  = 2'b11;
      bus.S_BVALID  = 2'b00;
      bus.S_BRESP0  = 2'b00;
      bus.S_BRESP1  = 2'b00;
      bus.M_BREADY  = 1'b0;
   endtask

   // One complete write from the master side with simple slave models.
   // Must be entered 1 time unit after a rising edge with the DUT in IDLE.
   task automatic run_write(input logic [31:0] addr, input logic [7:0] awlen,
                            input int nbeats, input logic [1:0] sresp,
                            input int wstall_at, input int wstall_n, input int bstall_n,
                            input logic exp_sel, input logic [1:0] exp_resp,
                            input string name);
      exp_t       e;
      exp_t       got;
      int         cyc = 0;
      int         mbeats = 0;
      int         sbeats = 0;
      int         stall = 0;
      int         bcnt = 0;
      int         bad = 0;
      logic       aw_done = 1'b0;
      logic       done = 1'b0;
      logic       aw_hs, w_hs, b_hs;
      logic [1:0] oh;
      logic [1:0] exp_awv;

      e.sel    = exp_sel;
      e.resp   = exp_resp;
      e.beats  = nbeats;
      e.cycles = 3 + nbeats + wstall_n + bstall_n;
      exp_q.push_back(e);
      oh = exp_sel ? 2'b10 : 2'b01;

      bus.M_AWVALID = 1'b1;
      bus.M_AWADDR  = addr;
      bus.M_AWLEN   = awlen;
      bus.M_WVALID  = 1'b1;
      bus.M_WLAST   = (nbeats == 1);
      bus.S_AWREADY = 2'b11;
      bus.S_WREADY  = 2'b11;
      bus.S_BVALID  = 2'b11;
      bus.S_BRESP0  = exp_sel ? (sresp ^ 2'b11) : sresp;
      bus.S_BRESP1  = exp_sel ? sresp : (sresp ^ 2'b11);
      bus.M_BREADY  = (bstall_n == 0);

      while (!done && cyc < 200) begin
         @(negedge ACLK);
         cyc++;
         aw_hs = bus.M_AWVALID & bus.M_AWREADY;
         w_hs  = bus.M_WVALID & bus.M_WREADY;
         b_hs  = bus.M_BVALID & bus.M_BREADY;
         exp_awv = (!aw_done && cyc >= 2) ? oh : 2'b00;
         if (bus.S_AWVALID !== exp_awv) bad++;
         if (bus.M_AWREADY !== (!aw_done && cyc >= 2)) bad++;
         if (!aw_done && bus.M_WREADY !== 1'b0) bad++;
         if (aw_done && mbeats < nbeats) begin
            if (bus.S_WVALID !== (bus.M_WVALID ? oh : 2'b00)) bad++;
            if (bus.M_WREADY !== |(bus.S_WREADY & oh)) bad++;
         end else if (bus.S_WVALID !== 2'b00) bad++;
         if (bus.S_BREADY !== ((bus.M_BVALID && bus.M_BREADY) ? oh : 2'b00)) bad++;
         if (cyc >= 2 && sel !== exp_sel) bad++;
         if (busy !== (cyc >= 2)) bad++;
         if (|(bus.S_WVALID & bus.S_WREADY & oh)) sbeats++;
         if (bus.M_BVALID && !bus.M_BREADY) bcnt++;
         if (b_hs) begin
            done = 1'b1;
            got = exp_q.pop_front();
            tests++;
            if (sel !== got.sel) begin
               fails++;
               $display("FAIL %s sel: got %0b expected %0b", name, sel, got.sel);
            end
            tests++;
            if (bus.M_BRESP !== got.resp) begin
               fails++;
               $display("FAIL %s bresp: got %02b expected %02b", name, bus.M_BRESP, got.resp);
            end
            tests++;
            if (mbeats !== got.beats || sbeats !== got.beats) begin
               fails++;
               $display("FAIL %s beats: master %0d slave %0d expected %0d", name, mbeats, sbeats, got.beats);
            end
            tests++;
            if (cyc !== got.cycles) begin
               fails++;
               $display("FAIL %s cycles: got %0d expected %0d", name, cyc, got.cycles);
            end
         end
         @(posedge ACLK);
         #1;
         if (aw_hs) begin
            bus.M_AWVALID = 1'b0;
            bus.M_AWADDR  = ~addr;   // late address changes must not move sel
            aw_done = 1'b1;
         end
         if (w_hs) begin
            mbeats++;
            if (mbeats == nbeats) bus.M_WVALID = 1'b0;
            bus.M_WLAST = (mbeats == nbeats - 1);
         end
         if (aw_done && mbeats == wstall_at && stall < wstall_n) begin
            bus.S_WREADY = ~oh;
            stall++;
         end else
            bus.S_WREADY = 2'b11;
         bus.M_BREADY = (bcnt >= bstall_n);
      end

      tests++;
      if (!done) begin
         fails++;
         $display("FAIL %s timeout: no B handshake after %0d cycles", name, cyc);
         void'(exp_q.pop_front());
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL %s gating: %0d bad cycles, expected 0", name, bad);
      end
      drive_idle();
   endtask

   task automatic test_reset();
      ARESET = 1'b1;
      drive_idle();
      bus.M_AWVALID = 1'b1;
      bus.M_WVALID  = 1'b1;
      bus.S_BVALID  = 2'b11;
      bus.M_BREADY  = 1'b1;
      repeat (2) @(posedge ACLK);
      #1;
      tests++;
      if (outs !== 13'd0) begin
         fails++;
         $display("FAIL reset_outputs: got %013b expected 0", outs);
      end
      drive_idle();
      @(negedge ACLK);
      ARESET = 1'b0;
      @(negedge ACLK);
      tests++;
      if (outs !== 13'd0) begin
         fails++;
         $display("FAIL reset_idle: got %013b expected 0", outs);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_single();
      run_write(32'h0000_1000, 8'd0, 1, 2'b00, -1, 0, 0, 1'b0, 2'b00, "single");
      @(negedge ACLK);
      tests++;
      if (busy !== 1'b0) begin
         fails++;
         $display("FAIL single_busy_after: got %0b expected 0", busy);
      end
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_burst();
      run_write(32'h8000_0000, 8'd3, 4, 2'b01, -1, 0, 0, 1'b1, 2'b01, "burst4");
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_back_to_back();
      // Second write is offered immediately after the B handshake; its cycle
      // count of 4 only holds if exactly one IDLE cycle sits in between.
      run_write(32'h7FFF_FFFF, 8'd0, 1, 2'b00, -1, 0, 0, 1'b0, 2'b00, "bound_lo");
      run_write(32'h8000_0000, 8'd0, 1, 2'b00, -1, 0, 0, 1'b1, 2'b00, "bound_hi");
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_len_mismatch();
      run_write(32'h0000_4000, 8'd3, 2, 2'b00, -1, 0, 0, 1'b0, 2'b10, "len_short");
      @(posedge ACLK);
      #1;
      run_write(32'h9000_0000, 8'd0, 3, 2'b00, -1, 0, 0, 1'b1, 2'b10, "len_long");
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_backpressure();
      run_write(32'h0000_8000, 8'd3, 4, 2'b01, 2, 3, 2, 1'b0, 2'b01, "backpressure");
      @(posedge ACLK);
      #1;
   endtask

   task automatic test_reset_mid();
      int   beats = 0;
      int   k = 0;
      logic aw_hs, w_hs;
      drive_idle();
      bus.M_AWVALID = 1'b1;
      bus.M_AWADDR  = 32'h0000_2000;
      bus.M_AWLEN   = 8'd7;
      bus.M_WVALID  = 1'b1;
      bus.S_BVALID  = 2'b11;
      bus.M_BREADY  = 1'b1;
      while (beats < 3 && k < 50) begin
         @(negedge ACLK);
         k++;
         aw_hs = bus.M_AWVALID & bus.M_AWREADY;
         w_hs  = bus.M_WVALID & bus.M_WREADY;
         @(posedge ACLK);
         #1;
         if (aw_hs) bus.M_AWVALID = 1'b0;
         if (w_hs) beats++;
      end
      tests++;
      if (beats !== 3 || bus.M_WREADY !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_setup: beats %0d wready %0b expected 3 and 1", beats, bus.M_WREADY);
      end
      #2;
      ARESET = 1'b1;
      #1;
      tests++;
      if (outs !== 13'd0) begin
         fails++;
         $display("FAIL rst_mid_outputs: got %013b expected 0", outs);
      end
      drive_idle();
      @(negedge ACLK);
      ARESET = 1'b0;
      @(posedge ACLK);
      #1;
      run_write(32'h8000_1234, 8'd0, 1, 2'b01, -1, 0, 0, 1'b1, 2'b01, "post_reset");
      @(posedge ACLK);
      #1;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_back_to_back();
      test_len_mismatch();
      test_backpressure();
      test_reset_mid();
      tests++;
      if (exp_q.size() !== 0) begin
         fails++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/axi_wr_route_ctrl.md
# axi_wr_route_ctrl

Write-channel routing controller for the single-master, two-slave AXI interconnect. It decodes each write address and registers a slave select that steers the AW, W and B demux/mux instances. It gates every valid and ready so that exactly one write transaction is in flight, and runs it through address, data and response in order. It also checks the W burst length against AWLEN and forces an SLVERR response when they disagree.

## Interface
- ADDR_WIDTH, 32: write address width.
- S1_BASE, 32'h8000_0000: addresses >= S1_BASE go to slave 1; all others go to slave 0.
- ACLK  in  1  clock; all logic on rising edge.
- ARESET  in  1  reset, asynchronous, active-high.
- M_AWVALID  in  1  master address valid.
- M_AWADDR  in  ADDR_WIDTH  master write address.
- M_AWLEN  in  8  burst length minus 1.
- M_AWREADY  out  1  address ready to master.
- S_AWVALID  out  2  per-slave address valid; bit n drives slave n.
- S_AWREADY  in  2  per-slave address ready.
- M_WVALID, M_WLAST  in  1 each  master data valid and last beat.
- M_WREADY  out  1  data ready to master.
- S_WVALID  out  2  per-slave data valid.
- S_WREADY  in  2  per-slave data ready.
- S_BVALID  in  2  per-slave response valid.
- S_BRESP0, S_BRESP1  in  2 each  slave response codes.
- S_BREADY  out  2  per-slave response ready.
- M_BVALID  out  1  response valid to master.
- M_BRESP  out  2  response code to master.
- M_BREADY  in  1  master response ready.
- sel  out  1  registered slave select; wired to the select input of the AW/W demux and the B mux.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, AW, W, B. Encoding is free. Only one transaction is outstanding.
- IDLE:
  - All gated outputs are 0.
  - When M_AWVALID=1: latch sel = (M_AWADDR >= S1_BASE), latch len = M_AWLEN, clear beat counter and len_err, then go to AW.
- AW:
  - S_AWVALID[sel] = M_AWVALID; the other bit is 0.
  - M_AWREADY = S_AWREADY[sel].
  - On handshake (M_AWVALID & M_AWREADY), go to W.
- W:
  - S_WVALID[sel] = M_WVALID.
  - M_WREADY = S_WREADY[sel].
  - Each handshake increments the 9-bit beat counter.
  - On a handshake with M_WLAST=1: set len_err = (beat counter != len), where the count is before the increment, then go to B.
  - A beat reaching len+1 without M_WLAST does not end the burst; only WLAST ends it, and len_err is set.
- B:
  - M_BVALID = S_BVALID[sel].
  - S_BREADY[sel] = M_BREADY.
  - M_BRESP = 2'b10 (SLVERR) if len_err, otherwise the selected S_BRESPn.
  - On handshake (M_BVALID & M_BREADY), go to IDLE.
- In every state, the unselected slave sees valid=0 and ready=0.
- Channel readies and valids are combinational from state, sel and inputs. There are no combinational paths from M_AWADDR to any output.
- Stray traffic is blocked: M_WVALID in IDLE or AW gets M_WREADY=0, and S_BVALID outside B gets S_BREADY=0.

## Timing
- Reset values: state=IDLE, sel=0, len=0, beat counter=0, len_err=0, busy=0. All outputs are 0; M_BRESP=2'b00.
- ARESET asserted mid-transaction: the FSM goes to IDLE immediately (asynchronous), gated outputs drop in the same cycle, and the transaction is abandoned.
- Address latency: M_AWVALID sampled in IDLE at edge N; earliest S_AWVALID during cycle N+1; earliest AW handshake at edge N+1.
- Data and response:
  - W beats pass at full throughput, one per cycle, while valid and ready are both held.
  - The earliest B state starts one cycle after the WLAST handshake.
- Turnaround: one IDLE cycle is mandatory between a B handshake and the next AW acceptance.
- Minimum transaction length for a single-beat burst with zero-wait slaves: 4 cycles (IDLE, AW, W, B).
- sel is stable from IDLE exit until return to IDLE. Changes in M_AWADDR after latching are ignored.
- Address boundary: M_AWADDR = S1_BASE-1 selects slave 0; M_AWADDR = S1_BASE selects slave 1.

## Test plan
- Single-beat write: AWADDR=0x0000_1000, AWLEN=0, zero-wait slave 0 -> sel=0, S_AWVALID=2'b01, one W beat, M_BRESP=S_BRESP0=2'b00, done in 4 cycles, busy low after.
- 4-beat burst: AWADDR=0x8000_0000, AWLEN=3, WLAST on beat 4 -> sel=1, only S_WVALID[1] toggles, 4 handshakes, M_BRESP=S_BRESP1.
- Boundary decode: AWADDR=0x7FFF_FFFF then 0x8000_0000 -> sel=0 then sel=1; one IDLE cycle between the transactions.
- Length mismatch: AWLEN=3, WLAST on beat 2; slave returns OKAY -> M_BRESP=2'b10. Also AWLEN=0 with WLAST on beat 3 -> 3 beats pass, M_BRESP=2'b10.
- Backpressure: S_WREADY[0] low for 3 cycles mid-burst, M_BREADY low 2 cycles -> no beat lost or duplicated, outputs held, S_BREADY[0] follows M_BREADY.
- Reset during W of an AWLEN=7 burst after beat 3 -> all outputs 0 in the same cycle, state IDLE. A following write to slave 1 completes normally with len_err=0.
